// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle between the command-stream bridge (master) and the
// addressed peripheral (slave). Five channels: AW, W, B, AR, R.
interface axi_lite_master_if #(
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 8
) ();

  // write address channel
  logic [ADDR_WD-1:0]   awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;

  // write data channel
  logic [DATA_WD-1:0]   wdata;
  logic [DATA_WD/8-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;

  // write response channel
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  // read address channel
  logic [ADDR_WD-1:0]   araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;

  // read data channel
  logic [DATA_WD-1:0]   rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid,    input wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input rready
  );

endinterface

// File: rtl/axi_lite_master.sv
// Command-stream to AXI4-Lite master bridge. Each accepted beat is
// {addr, data} with a byte keep: full keep issues a write, address-only keep
// issues a read, anything else is consumed and dropped. One transaction is in
// flight at a time; completions are reported on one-cycle done strobes.
module axi_lite_master #(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 8,
  parameter int KEEP_WD = (ADDR_WD + DATA_WD) >> 3
) (
  input  logic                       clk,
  input  logic                       rst_n,

  input  logic                       tvalid,
  input  logic [ADDR_WD+DATA_WD-1:0] tdata,
  input  logic [KEEP_WD-1:0]         tkeep,
  output logic                       tready,

  axi_lite_master_if.master          axi,

  output logic                       wr_done,
  output logic [1:0]                 wr_resp,
  output logic                       rd_done,
  output logic [DATA_WD-1:0]         rd_data,
  output logic [1:0]                 rd_resp
);

  localparam int DBYTES = DATA_WD / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R
  } state_e;

  state_e               state_q,   state_d;
  logic [ADDR_WD-1:0]   addr_q,    addr_d;
  logic [DATA_WD-1:0]   data_q,    data_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q,  wvalid_d;
  logic                 bready_q,  bready_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q,  rready_d;
  logic                 wr_done_q, wr_done_d;
  logic [1:0]           wr_resp_q, wr_resp_d;
  logic                 rd_done_q, rd_done_d;
  logic [DATA_WD-1:0]   rd_data_q, rd_data_d;
  logic [1:0]           rd_resp_q, rd_resp_d;

  logic                 fire;
  logic                 addr_kept;
  logic                 data_kept;
  logic                 data_none;

  // Ready is a decode of the state register only, so no ready->valid path.
  assign tready    = (state_q == IDLE);
  assign fire      = tvalid && tready;

  // Keep groups: upper bytes cover the address, lower bytes the data.
  assign addr_kept = &tkeep[KEEP_WD-1:DBYTES];
  assign data_kept = &tkeep[DBYTES-1:0];
  assign data_none = ~|tkeep[DBYTES-1:0];

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    // NOTE: every *_d takes its held value first, so no branch can leave a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    wr_done_d = 1'b0;
    wr_resp_d = wr_resp_q;
    rd_done_d = 1'b0;
    rd_data_d = rd_data_q;
    rd_resp_d = rd_resp_q;

    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (addr_kept && data_kept) begin
            state_d   = WR;
            addr_d    = tdata[ADDR_WD+DATA_WD-1:DATA_WD];
            data_d    = tdata[DATA_WD-1:0];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else if (addr_kept && data_none) begin
            state_d   = RD_AR;
            addr_d    = tdata[ADDR_WD+DATA_WD-1:DATA_WD];
            arvalid_d = 1'b1;
          end
          // any other keep pattern: beat is consumed and dropped
        end
      end

      WR: begin
        // AW and W retire independently; move on once both have handshaken.
        if (awvalid_q && axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end

      WR_B: begin
        if (axi.bvalid && bready_q) begin
          bready_d  = 1'b0;
          wr_done_d = 1'b1;
          wr_resp_d = axi.bresp;
          state_d   = IDLE;
        end
      end

      RD_AR: begin
        if (arvalid_q && axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end

      RD_R: begin
        if (axi.rvalid && rready_q) begin
          rready_d  = 1'b0;
          rd_done_d = 1'b1;
          rd_data_d = axi.rdata;
          rd_resp_d = axi.rresp;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wr_done_q <= 1'b0;
      wr_resp_q <= 2'b00;
      rd_done_q <= 1'b0;
      rd_data_q <= '0;
      rd_resp_q <= 2'b00;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wr_done_q <= wr_done_d;
      wr_resp_q <= wr_resp_d;
      rd_done_q <= rd_done_d;
      rd_data_q <= rd_data_d;
      rd_resp_q <= rd_resp_d;
    end
  end

  // Bus drive: one address register serves both AW and AR.
  assign axi.awaddr  = addr_q;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = data_q;
  assign axi.wstrb   = '1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign wr_done     = wr_done_q;
  assign wr_resp     = wr_resp_q;
  assign rd_done     = rd_done_q;
  assign rd_data     = rd_data_q;
  assign rd_resp     = rd_resp_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: table of single-beat vectors plus hand-written
// sequences for slow W, mid-transaction reset and back-to-back streams.
module tb_axi_lite_master;

  localparam int DATA_WD = 8;
  localparam int ADDR_WD = 8;
  localparam int KEEP_WD = (ADDR_WD + DATA_WD) >> 3;

  typedef enum logic [1:0] {K_WR, K_RD, K_DROP} kind_e;

  typedef struct {
    logic [KEEP_WD-1:0] keep;
    logic [15:0]        tdata;
    kind_e              kind;
    logic [7:0]         s_rdata;   // slave read data
    logic [1:0]         s_resp;    // slave bresp / rresp
    logic [7:0]         exp_addr;
    logic [7:0]         exp_data;  // wdata for writes, rd_data for reads
    logic [1:0]         exp_resp;
  } vec_t;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 tvalid;
  logic [15:0]          tdata;
  logic [KEEP_WD-1:0]   tkeep;
  logic                 tready;
  logic                 wr_done;
  logic [1:0]           wr_resp;
  logic                 rd_done;
  logic [7:0]           rd_data;
  logic [1:0]           rd_resp;

  axi_lite_master_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD)) ax ();

  axi_lite_master #(.DATA_WD(DATA_WD), .ADDR_WD(ADDR_WD), .KEEP_WD(KEEP_WD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tvalid  (tvalid),
    .tdata   (tdata),
    .tkeep   (tkeep),
    .tready  (tready),
    .axi     (ax),
    .wr_done (wr_done),
    .wr_resp (wr_resp),
    .rd_done (rd_done),
    .rd_data (rd_data),
    .rd_resp (rd_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------- slave
  int         w_delay   = 0;      // cycles after AW handshake before wready
  bit         b_hold    = 1'b0;   // withhold bvalid
  bit         err_en    = 1'b0;
  logic [7:0] err_addr  = 8'h00;  // write to this address answers SLVERR
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;
  logic [7:0] rdata_cfg = 8'h00;
  bit         r_xor     = 1'b0;   // rdata = araddr ^ 8'h5A

  // handshakes due on the coming posedge
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
  bit aw_seen, w_seen, ar_seen;
  int w_wait;
  logic [7:0] aw_addr_s, ar_addr_s;
  bit   p_awv, p_wv, p_arv;
  logic [7:0] p_awaddr, p_wdata, p_araddr;

  logic [7:0] aw_log[$], w_log[$], ar_log[$], rd_log[$];
  logic [1:0] wr_resp_log[$];
  int wr_done_cnt, rd_done_cnt, any_valid_cnt;
  int proto_err = 0;

  // Slave and bus monitor: decides readies/responses on the falling edge so
  // they are stable for the DUT's rising edge, and logs each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      ax.awready = 1'b0; ax.wready = 1'b0; ax.arready = 1'b0;
      ax.bvalid  = 1'b0; ax.bresp  = 2'b00;
      ax.rvalid  = 1'b0; ax.rdata  = 8'h00; ax.rresp = 2'b00;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; w_wait = 0;
      p_awv = 0; p_wv = 0; p_arv = 0;
    end else begin
      // valid must hold with stable payload until its handshake
      if (p_awv && !aw_hs && (!ax.awvalid || ax.awaddr !== p_awaddr)) proto_err++;
      if (p_wv  && !w_hs  && (!ax.wvalid  || ax.wdata  !== p_wdata))  proto_err++;
      if (p_arv && !ar_hs && (!ax.arvalid || ax.araddr !== p_araddr)) proto_err++;

      // retire handshakes completed on the rising edge just gone
      if (aw_hs) begin aw_seen = 1; w_wait = 0; end
      else if (aw_seen) w_wait++;
      if (w_hs)  w_seen  = 1;
      if (ar_hs) ar_seen = 1;
      if (b_hs)  ax.bvalid = 1'b0;
      if (r_hs)  ax.rvalid = 1'b0;

      if (aw_seen && w_seen && !ax.bvalid && !b_hold) begin
        ax.bvalid = 1'b1;
        ax.bresp  = (err_en && aw_addr_s == err_addr) ? 2'b10 : bresp_cfg;
        aw_seen = 0; w_seen = 0;
      end
      if (ar_seen && !ax.rvalid) begin
        ax.rvalid = 1'b1;
        ax.rdata  = r_xor ? (ar_addr_s ^ 8'h5A) : rdata_cfg;
        ax.rresp  = rresp_cfg;
        ar_seen = 0;
      end

      ax.awready = 1'b1;
      ax.arready = 1'b1;
      ax.wready  = (w_delay == 0) || (aw_seen && w_wait >= w_delay);

      aw_hs = ax.awvalid && ax.awready;
      w_hs  = ax.wvalid  && ax.wready;
      ar_hs = ax.arvalid && ax.arready;
      b_hs  = ax.bvalid  && ax.bready;
      r_hs  = ax.rvalid  && ax.rready;
      if (aw_hs) begin aw_addr_s = ax.awaddr; aw_log.push_back(ax.awaddr); end
      if (w_hs)  w_log.push_back(ax.wdata);
      if (ar_hs) begin ar_addr_s = ax.araddr; ar_log.push_back(ax.araddr); end
      if (wr_done) begin wr_done_cnt++; wr_resp_log.push_back(wr_resp); end
      if (rd_done) begin rd_done_cnt++; rd_log.push_back(rd_data); end
      if (ax.awvalid || ax.wvalid || ax.arvalid) any_valid_cnt++;

      p_awv = ax.awvalid; p_awaddr = ax.awaddr;
      p_wv  = ax.wvalid;  p_wdata  = ax.wdata;
      p_arv = ax.arvalid; p_araddr = ax.araddr;
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); ar_log.delete(); rd_log.delete();
    wr_resp_log.delete();
    wr_done_cnt = 0; rd_done_cnt = 0; any_valid_cnt = 0;
  endtask

  // Called on a falling edge; returns on the first falling edge after the fire.
  task automatic send_beat(input logic [KEEP_WD-1:0] k, input logic [15:0] d, output bit ok);
    int n = 0;
    tvalid = 1'b1; tdata = d; tkeep = k;
    while (!tready && n < 50) begin @(negedge clk); n++; end
    ok = tready;
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  // Counts falling edges until a done pulse; tr_ok holds when tready stayed
  // low before the pulse and is high alongside it.
  task automatic wait_done(input int start, output int n, output bit tr_ok);
    n = start;
    tr_ok = 1'b1;
    while (!(wr_done || rd_done) && n < 40) begin
      if (tready) tr_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!tready) tr_ok = 1'b0;
  endtask

  // Keeps tvalid high and advances the beat after every acceptance.
  task automatic stream(input logic [KEEP_WD-1:0] k, input bit is_wr, output int sent);
    int idx   = 0;
    int guard = 0;
    logic [7:0] a;
    tkeep  = k;
    tvalid = 1'b1;
    tdata  = is_wr ? 16'h00FF : 16'h0000;
    while (idx < 256 && guard < 5000) begin
      bit fire_now;
      fire_now = tready;
      @(negedge clk);
      guard++;
      if (fire_now) begin
        idx++;
        a     = idx[7:0];
        tdata = is_wr ? {a, ~a} : {a, 8'h00};
      end
    end
    tvalid = 1'b0;
    sent   = idx;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- test
  vec_t vecs[7];

  initial begin
    bit ok;
    bit tr_ok;
    int n;
    int sent;
    int err;
    logic [7:0] a;

    vecs[0] = '{2'b11, 16'h0505, K_WR,   8'h00, 2'b00, 8'h05, 8'h05, 2'b00};
    vecs[1] = '{2'b10, 16'h2A00, K_RD,   8'h5C, 2'b00, 8'h2A, 8'h5C, 2'b00};
    vecs[2] = '{2'b11, 16'hC3A5, K_WR,   8'h00, 2'b11, 8'hC3, 8'hA5, 2'b11};
    vecs[3] = '{2'b10, 16'h7711, K_RD,   8'hA3, 2'b10, 8'h77, 8'hA3, 2'b10};
    vecs[4] = '{2'b01, 16'h1234, K_DROP, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00};
    vecs[5] = '{2'b00, 16'h5678, K_DROP, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00};
    vecs[6] = '{2'b11, 16'h00FF, K_WR,   8'h00, 2'b01, 8'h00, 8'hFF, 2'b01};

    tvalid = 1'b0; tdata = '0; tkeep = '0;
    clear_logs();

    // reset held for 100 ns
    rst_n = 1'b0;
    #100;
    check("reset valids/readies/done", {ax.awvalid, ax.wvalid, ax.arvalid, ax.bready,
                                         ax.rready, wr_done, rd_done}, 7'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("reset tready", tready, 1'b1);
    check("prot fields", {ax.awprot, ax.arprot}, 6'b0);

    // table-driven single beats, always-ready slave
    for (int i = 0; i < 7; i++) begin
      clear_logs();
      rdata_cfg = vecs[i].s_rdata;
      bresp_cfg = vecs[i].s_resp;
      rresp_cfg = vecs[i].s_resp;
      send_beat(vecs[i].keep, vecs[i].tdata, ok);
      check($sformatf("v%0d accepted", i), ok, 1'b1);
      if (vecs[i].kind == K_DROP) begin
        repeat (6) @(negedge clk);
        check($sformatf("v%0d no AXI valid", i), any_valid_cnt, 0);
        check($sformatf("v%0d no done", i), wr_done_cnt + rd_done_cnt, 0);
        check($sformatf("v%0d tready", i), tready, 1'b1);
      end else begin
        wait_done(1, n, tr_ok);
        check($sformatf("v%0d latency", i), n, 3);
        check($sformatf("v%0d tready low then high", i), tr_ok, 1'b1);
        if (vecs[i].kind == K_WR) begin
          check($sformatf("v%0d wr_done", i), wr_done, 1'b1);
          check($sformatf("v%0d wr_resp", i), wr_resp, vecs[i].exp_resp);
        end else begin
          check($sformatf("v%0d rd_done", i), rd_done, 1'b1);
          check($sformatf("v%0d rd_data", i), rd_data, vecs[i].exp_data);
          check($sformatf("v%0d rd_resp", i), rd_resp, vecs[i].exp_resp);
        end
        @(negedge clk);
        check($sformatf("v%0d done one cycle", i), {wr_done, rd_done}, 2'b00);
        if (vecs[i].kind == K_WR) begin
          check($sformatf("v%0d awaddr", i), (aw_log.size() == 1) ? aw_log[0] : 8'bx, vecs[i].exp_addr);
          check($sformatf("v%0d wdata", i), (w_log.size() == 1) ? w_log[0] : 8'bx, vecs[i].exp_data);
          check($sformatf("v%0d wstrb", i), ax.wstrb, 1'b1);
          check($sformatf("v%0d single wr_done, no AR", i), {wr_done_cnt, ar_log.size()}, {32'd1, 32'd0});
        end else begin
          check($sformatf("v%0d araddr", i), (ar_log.size() == 1) ? ar_log[0] : 8'bx, vecs[i].exp_addr);
          check($sformatf("v%0d single rd_done, no AW", i), {rd_done_cnt, aw_log.size()}, {32'd1, 32'd0});
        end
      end
    end
    bresp_cfg = 2'b00; rresp_cfg = 2'b00;

    // slow W: wready arrives 3 cycles after the AW handshake
    clear_logs();
    w_delay = 3;
    send_beat(2'b11, 16'h3C96, ok);
    check("slow-w both valid", {ax.awvalid, ax.wvalid}, 2'b11);
    @(negedge clk);
    check("slow-w aw drops first", {ax.awvalid, ax.wvalid}, 2'b01);
    check("slow-w wdata held", ax.wdata, 8'h96);
    wait_done(2, n, tr_ok);
    check("slow-w latency", n, 7);
    check("slow-w tready", tr_ok, 1'b1);
    @(negedge clk);
    check("slow-w single wr_done", wr_done_cnt, 1);
    check("slow-w wdata logged", (w_log.size() == 1) ? w_log[0] : 8'bx, 8'h96);
    w_delay = 0;

    // reset while waiting for B
    clear_logs();
    b_hold = 1'b1;
    send_beat(2'b11, 16'h4411, ok);
    @(negedge clk);
    check("mid-reset bready up", ax.bready, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid-reset bready drops at once", ax.bready, 1'b0);
    check("mid-reset valids", {ax.awvalid, ax.wvalid, ax.arvalid}, 3'b000);
    b_hold = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid-reset tready after release", tready, 1'b1);
    check("mid-reset no wr_done", wr_done_cnt, 0);
    send_beat(2'b11, 16'h5522, ok);
    wait_done(1, n, tr_ok);
    check("post-reset write latency", n, 3);

    // 256 back-to-back writes, one of them answered with SLVERR
    repeat (2) @(negedge clk);
    clear_logs();
    err_en = 1'b1; err_addr = 8'h80;
    stream(2'b11, 1'b1, sent);
    err_en = 1'b0;
    check("wstream beats sent", sent, 256);
    check("wstream wr_done count", wr_done_cnt, 256);
    check("wstream AW/W counts", {aw_log.size(), w_log.size()}, {32'd256, 32'd256});
    err = 0;
    for (int i = 0; i < 256 && i < aw_log.size() && i < w_log.size(); i++) begin
      a = i[7:0];
      if (aw_log[i] !== a || w_log[i] !== ~a) err++;
    end
    check("wstream order/payload errors", err, 0);
    check("wstream SLVERR reported", (wr_resp_log.size() > 128) ? wr_resp_log[128] : 2'bx, 2'b10);
    err = 0;
    for (int i = 0; i < wr_resp_log.size(); i++)
      if (i != 128 && wr_resp_log[i] !== 2'b00) err++;
    check("wstream other resp errors", err, 0);

    // 256 back-to-back reads
    clear_logs();
    r_xor = 1'b1;
    stream(2'b10, 1'b0, sent);
    r_xor = 1'b0;
    check("rstream beats sent", sent, 256);
    check("rstream rd_done count, no AW", {rd_done_cnt, aw_log.size()}, {32'd256, 32'd0});
    err = 0;
    for (int i = 0; i < 256 && i < ar_log.size() && i < rd_log.size(); i++) begin
      a = i[7:0];
      if (ar_log[i] !== a || rd_log[i] !== (a ^ 8'h5A)) err++;
    end
    check("rstream order/data errors", err + (256 - rd_log.size()), 0);

    check("bus protocol violations", proto_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
